serial_sub5: RTL



---
 rtl/serial_arith_pkg.sv | 13 +
 rtl/serial_sub5_fa.sv | 13 +
 rtl/serial_sub5.sv | 127 ++++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} ser_state_t;

  localparam int unsigned DEFAULT_WIDTH = 5;

  // Bits needed to count 0..w-1 (w >= 2).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_sub5_fa.sv
// One-bit full-adder slice from the shared arithmetic library.
module FA (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/serial_sub5.sv
// Bit-serial two's-complement subtractor, LSB first, one FA slice plus carry flop.
// Define SERIAL_ADDSUB_EN to add an op port selecting add (1) or subtract (0).
module serial_sub5
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_ADDSUB_EN
  input  logic             op,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             OF
);

  localparam int unsigned CW = cnt_width(WIDTH);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             bout_q, bout_d;
  logic             of_q, of_d;
  logic             add_q, add_d;
  logic             add_in;
  logic             sum, cout;

`ifdef SERIAL_ADDSUB_EN
  assign add_in = op;
`else
  assign add_in = 1'b0;
`endif

  FA u_fa (
    .a_i  (areg_q[0]),
    .b_i  (breg_q[0]),
    .ci_i (carry_q),
    .s_o  (sum),
    .co_o (cout)
  );

  always_comb begin
    state_d = state_q;
    areg_d  = areg_q;
    breg_d  = breg_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    bout_d  = bout_q;
    of_d    = of_q;
    add_d   = add_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          areg_d  = A;
          // Subtract is A + ~B + 1; the +1 enters through the initial carry.
          breg_d  = add_in ? B : ~B;
          carry_d = ~add_in;
          add_d   = add_in;
          cnt_d   = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        res_d   = {sum, res_q[WIDTH-1:1]};
        areg_d  = areg_q >> 1;
        breg_d  = breg_q >> 1;
        carry_d = cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          d_d     = {sum, res_q[WIDTH-1:1]};
          bout_d  = add_q ? cout : ~cout;
          // carry_q is the carry into the MSB on this final step.
          of_d    = cout ^ carry_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      areg_q  <= '0;
      breg_q  <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      of_q    <= 1'b0;
      add_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      areg_q  <= areg_d;
      breg_q  <= breg_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      bout_q  <= bout_d;
      of_q    <= of_d;
      add_q   <= add_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign D    = d_q;
  assign Bout = bout_q;
  assign OF   = of_q;

endmodule
